// File: rtl/mux_nto1_stream_pkg.sv
// Shared definitions for the N:1 stream mux and related arbiter blocks.
package mux_nto1_stream_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Index `step` positions after `idx`, wrapping at n (step <= n, idx < n).
    function automatic int wrap_add(int idx, int step, int n);
        int r;
        r = idx + step;
        if (r >= n) r = r - n;
        return r;
    endfunction

endpackage

// File: rtl/mux_nto1_stream_if.sv
// Producer-side and consumer-side stream signals of the N:1 mux.
interface mux_nto1_stream_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_nto1_stream_rr_arbiter.sv
// Combinational round-robin pick: first requester after `last`, wrapping.
module rr_arbiter
    import mux_nto1_stream_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);

    logic [CHANNELS-1:0] shifted;
    int                  idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        shifted     = '0;
        idx         = 0;
        // Walk the scan order backwards so the nearest requester after `last` wins.
        for (int k = CHANNELS; k >= 1; k--) begin
            idx     = wrap_add(int'(last), k, CHANNELS);
            shifted = req >> idx;
            if (shifted[0]) begin
                grant       = SEL_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_stream.sv
// N:1 stream mux, direct-select or round-robin, with a one-beat registered output.
module mux_nto1_stream
    import mux_nto1_stream_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_nto1_stream_if.slave      bus
);

    logic [SEL_W-1:0] rr_last;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_gv;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] chan_q;
    logic             vld_q;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req         (bus.in_valid),
        .last        (rr_last),
        .grant       (rr_grant),
        .grant_valid (rr_gv)
    );

    always_comb begin
        load_en = !vld_q || bus.out_ready;
        if (bus.mode == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_gv;
        end else begin
            grant       = bus.sel;
            grant_valid = int'(bus.sel) < CHANNELS;
        end
    end

    // Ready is held low during reset so no producer handshake completes then.
    assign bus.in_ready = (!rst && load_en && grant_valid) ? (CHANNELS'(1) << grant) : '0;
    assign xfer         = |(bus.in_ready & bus.in_valid);

    always_comb begin
        sel_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant == SEL_W'(c)) sel_data = bus.in_data[c*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            vld_q   <= 1'b0;
            rr_last <= SEL_W'(CHANNELS - 1);
        end else if (xfer) begin
            data_q <= sel_data;
            chan_q <= grant;
            vld_q  <= 1'b1;
            if (bus.mode == MODE_RR) rr_last <= grant;
        end else if (bus.out_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Scoreboard bench for mux_nto1_stream: two configurations, directed then random traffic.
module tb_mux_nto1_stream;
  import mux_nto1_stream_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_nto1_stream_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(3)) bus_a ();
  mux_nto1_stream_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) bus_b ();

  mux_nto1_stream #(.WIDTH(4), .CHANNELS(4), .SEL_W(3)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  mux_nto1_stream #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Expected beats as {chan, data}, oldest first.
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  logic m_valid[2] = '{1'b0, 1'b0};
  int   m_last[2]  = '{3, 2};
  bit   started[2] = '{1'b0, 1'b0};
  bit   just_rst[2] = '{1'b0, 1'b0};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel the rules say should be granted, or -1.
  function automatic int ref_grant(logic mode, int sel, logic [15:0] valid, int last, int ch);
    if (mode == 1'b0) return (sel < ch) ? sel : -1;
    for (int k = 1; k <= ch; k++) begin
      int i;
      i = (last + k) % ch;
      if (((valid >> i) & 16'd1) != 16'd0) return i;
    end
    return -1;
  endfunction

  task automatic model_step(int d, int ch, int width, logic mode, int sel, logic [15:0] valid,
                            logic [127:0] data, logic [15:0] rdy, logic ovld,
                            logic [7:0] odata, int ochan, logic ordy);
    int g;
    logic [15:0] exp_rdy;
    logic [7:0] beat;
    string tag;
    tag = (d == 0) ? "a" : "b";
    g = ref_grant(mode, sel, valid, m_last[d], ch);
    exp_rdy = '0;
    if (!rst && (!m_valid[d] || ordy) && g >= 0) exp_rdy = 16'd1 << g;
    check({tag, ".in_ready"}, 32'(rdy), 32'(exp_rdy));
    if (started[d]) check({tag, ".out_valid"}, 32'(ovld), 32'(m_valid[d]));
    if (just_rst[d]) begin
      check({tag, ".rst_out_data"}, 32'(odata), 32'd0);
      check({tag, ".rst_out_chan"}, 32'(ochan), 32'd0);
      just_rst[d] = 1'b0;
    end
    if (rst) begin
      m_valid[d] = 1'b0;
      m_last[d]  = ch - 1;
      if (d == 0) q_a.delete(); else q_b.delete();
      started[d]  = 1'b1;
      just_rst[d] = 1'b1;
    end else if (exp_rdy != 16'd0 && ((valid >> g) & 16'd1) != 16'd0) begin
      beat = 8'((data >> (g * width)) & ((128'd1 << width) - 128'd1));
      if (d == 0) q_a.push_back({8'(g), beat}); else q_b.push_back({8'(g), beat});
      m_valid[d] = 1'b1;
      if (mode) m_last[d] = g;
    end else if (ordy) begin
      m_valid[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    model_step(0, 4, 4, bus_a.mode, int'(bus_a.sel), 16'(bus_a.in_valid), 128'(bus_a.in_data),
               16'(bus_a.in_ready), bus_a.out_valid, 8'(bus_a.out_data), int'(bus_a.out_chan),
               bus_a.out_ready);
    model_step(1, 3, 8, bus_b.mode, int'(bus_b.sel), 16'(bus_b.in_valid), 128'(bus_b.in_data),
               16'(bus_b.in_ready), bus_b.out_valid, 8'(bus_b.out_data), int'(bus_b.out_chan),
               bus_b.out_ready);
  end

  // Monitor: compare the presented beat against the oldest expected one; pop on handshake.
  task automatic mon(int d, logic [7:0] odata, int ochan, logic ordy);
    logic [15:0] head;
    string tag;
    tag = (d == 0) ? "a" : "b";
    if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
      check({tag, ".unexpected_beat"}, {8'(ochan), odata}, 32'hDEAD);
      return;
    end
    head = (d == 0) ? q_a[0] : q_b[0];
    check({tag, ".out_beat"}, 32'({8'(ochan), odata}), 32'(head));
    if (ordy) begin
      if (d == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus_a.out_valid) mon(0, 8'(bus_a.out_data), int'(bus_a.out_chan), bus_a.out_ready);
    if (!rst && bus_b.out_valid) mon(1, bus_b.out_data, int'(bus_b.out_chan), bus_b.out_ready);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(logic mode, logic [2:0] sel, logic [3:0] valid, logic [15:0] data, logic ordy);
    bus_a.mode = mode; bus_a.sel = sel; bus_a.in_valid = valid;
    bus_a.in_data = data; bus_a.out_ready = ordy;
  endtask

  initial begin
    drive_a(MODE_RR, 3'd0, 4'b1111, 16'h4321, 1'b1);
    bus_b.mode = MODE_RR; bus_b.sel = '0; bus_b.in_valid = '0;
    bus_b.in_data = '0; bus_b.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Round-robin, all valid: 0,1,2,3,0,1,2,3 with data 1,2,3,4,...
    repeat (8) step();

    // Direct select of channel 2, then an out-of-range select.
    drive_a(MODE_SEL, 3'd2, 4'b0100, 16'h0A00, 1'b1);
    step();
    drive_a(MODE_SEL, 3'd5, 4'b0100, 16'h0A00, 1'b1);
    step();
    step();

    // Back-pressure: hold 5 for three cycles while ch1 waits with 7.
    drive_a(MODE_SEL, 3'd1, 4'b0010, 16'h0050, 1'b1);
    step();
    drive_a(MODE_SEL, 3'd1, 4'b0010, 16'h0070, 1'b0);
    repeat (3) step();
    bus_a.out_ready = 1'b1;
    step();

    // Reset with a beat pending: it must vanish.
    drive_a(MODE_SEL, 3'd1, 4'b0010, 16'h0090, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Skip and wrap: last=1, then 1001 gives 3 then 0; then idle drains.
    drive_a(MODE_RR, 3'd0, 4'b0010, 16'h00B0, 1'b1);
    step();
    drive_a(MODE_RR, 3'd0, 4'b1001, 16'hC00D, 1'b1);
    step();
    step();
    drive_a(MODE_RR, 3'd0, 4'b0000, 16'h0000, 1'b1);
    repeat (2) step();

    // Random traffic on both configurations.
    for (int n = 0; n < 2000; n++) begin
      bus_a.mode      = 1'($urandom_range(0, 1));
      bus_a.sel       = 3'($urandom_range(0, 7));
      bus_a.in_valid  = 4'($urandom);
      bus_a.in_data   = 16'($urandom);
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      bus_b.mode      = 1'($urandom_range(0, 1));
      bus_b.sel       = 2'($urandom_range(0, 3));
      bus_b.in_valid  = 3'($urandom);
      bus_b.in_data   = 24'($urandom);
      bus_b.out_ready = ($urandom_range(0, 3) != 0);
      rst             = ($urandom_range(0, 299) == 0);
      step();
    end

    rst = 1'b0;
    bus_a.in_valid = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = '0; bus_b.out_ready = 1'b1;
    repeat (3) step();
    check("a.drain_left", 32'(q_a.size()), 32'd0);
    check("b.drain_left", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
